uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial UART transmit stage that sits directly upstream of the receiver. It drives the `onebit_data` line the receiver samples. On a send-button press it latches the byte on `sw[7:0]` and shifts out one frame, LSB first, at a fixed baud rate: start bit, 8 data bits, optional parity bit, stop bit. It then returns to idle with the line held high.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per serial bit (50 MHz / 9600 baud); legal range ≥ 2.
- `clk` input 1: system clock; all state updates on rising edge.
- `btn0` input 1: reset; synchronous, active-high.
- `btn1` input 1: send request; asynchronous push-button level, internally synchronized and edge-detected.
- `sw` input 8: byte to transmit; sampled once, on the cycle the send edge is accepted.
- `onebit_data` output 1: serial line; idle high; registered.
- `busy` output 1: high from frame start until the stop bit completes; registered.
- `led` output 8: copy of the last accepted byte; registered.

## Operation
- Reset (`btn0` high at a clock edge): state IDLE, `onebit_data`=1, `busy`=0, `led`=8'h00. Baud counter, bit index, synchronizer and edge-detect flops all clear to 0.
- `btn1` passes through a 2-flop synchronizer (`s1`, `s2`) plus a history flop `s3`. A send edge is `s2 & ~s3`.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE:
  - Line high, `busy`=0.
  - On a send edge: latch `sw` into the shift register and into `led`, set `busy`=1, drive `onebit_data`=0, clear the baud counter, go to START.
- START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - Drive shift-register bit [index].
  - Each bit is held CLKS_PER_BIT cycles.
  - After index 7, go to PARITY if enabled, else STOP.
- PARITY: drive the XOR of the 8 latched bits (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: drive 1 for CLKS_PER_BIT cycles, then go to IDLE with `busy`=0.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Bit transition happens on the cycle the counter equals CLKS_PER_BIT-1; the counter wraps to 0 in that same cycle.
  - Counter width is $clog2(CLKS_PER_BIT).
- Boundary conditions:
  - Send edge while `busy`=1: ignored and not queued. `s3` still tracks `s2`, so a button held across the end of a frame does not retrigger.
  - `btn1` held high indefinitely: exactly one frame.
  - `sw` changing mid-frame: no effect on the frame in flight or on `led`.
  - Reset mid-frame: next cycle the line is 1 and `busy`=0; the partial frame is abandoned.
  - `btn0` and a send edge in the same cycle: reset wins.

## Timing
- `btn1` first sampled high at edge k. `s1` is set at k, `s2` at k+1, and the send edge is accepted at k+2.
- `onebit_data` falls and `busy` rises immediately after edge k+2; `sw` is sampled at edge k+2.
- Every bit lasts exactly CLKS_PER_BIT cycles.
- Frame length: 10×CLKS_PER_BIT cycles without parity, 11×CLKS_PER_BIT with parity.
- `busy` falls in the same cycle the line returns to idle after the stop bit.
- The earliest next frame can start 3 cycles after a new `btn1` low→high transition, counted once `busy`=0.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - An even-parity bit is inserted between data bit 7 and the stop bit.
  - Frame is 11 bits.
- Undefined:
  - No PARITY state.
  - Frame is 10 bits, 8N1.
  - The downstream receiver expects this default.

## Test plan
- Reset, then CLKS_PER_BIT=4, sw=8'hA5, pulse btn1 → line low at k+2; line sequence 0,1,0,1,0,0,1,0,1,1 with each level held exactly 4 cycles; `busy` high for 40 cycles; `led`=8'hA5.
- Hold btn1 high for 200 cycles with sw=8'h3C → exactly one frame; line stays high afterwards; `busy`=0.
- Second press mid-frame with sw changed to 8'hFF → ignored; frame bits still encode 8'h3C; `led` stays 8'h3C.
- Assert btn0 during data bit 3 → the next cycle has line=1 and `busy`=0; a later press sends a full clean frame.
- With UART_TX_PARITY_EN: sw=8'h01 gives parity bit 1 and a 44-cycle frame; sw=8'hA5 gives parity bit 0.
- Loopback into the receiver, sw=8'h5A → receiver `led` shows 8'h5A after the stop bit.

Source files
------------

// File: rtl/uart_transmitter_if.sv
// Transmit-side bundle between the send-button/switch logic and the UART
// transmitter: send request and byte in, serial line, busy flag and byte echo out.
interface uart_transmitter_if;
  logic       btn1;
  logic [7:0] sw;
  logic       onebit_data;
  logic       busy;
  logic [7:0] led;

  modport master (
    output btn1,
    output sw,
    input  onebit_data,
    input  busy,
    input  led
  );

  modport slave (
    input  btn1,
    input  sw,
    output onebit_data,
    output busy,
    output led
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmit stage: one LSB-first frame per synchronized send-button edge.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1); default is 8N1.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic               clk,
  input  logic               btn0,
  uart_transmitter_if.slave  tx_if
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic [7:0]       shift_r;
  logic             line_r;
  logic             busy_r;
  logic [7:0]       led_r;
  logic             s1_r;
  logic             s2_r;
  logic             s3_r;
  logic             send_edge_s;
  logic             bit_done_s;

  assign send_edge_s = s2_r & ~s3_r;
  assign bit_done_s  = (cnt_r == CNT_LAST);

  assign tx_if.onebit_data = line_r;
  assign tx_if.busy        = busy_r;
  assign tx_if.led         = led_r;

  // Button synchronizer, baud timing and frame sequencing with registered outputs.
  always_ff @(posedge clk) begin
    if (btn0) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      line_r  <= 1'b1;
      busy_r  <= 1'b0;
      led_r   <= 8'h00;
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      s3_r    <= 1'b0;
    end else begin
      // s3 follows s2 even mid-frame so a held button cannot retrigger later.
      s1_r <= tx_if.btn1;
      s2_r <= s1_r;
      s3_r <= s2_r;
      case (state_r)
        IDLE: begin
          line_r <= 1'b1;
          busy_r <= 1'b0;
          if (send_edge_s) begin
            shift_r <= tx_if.sw;
            led_r   <= tx_if.sw;
            busy_r  <= 1'b1;
            line_r  <= 1'b0;
            cnt_r   <= CNT_ZERO;
            state_r <= START;
          end
        end
        START: begin
          if (bit_done_s) begin
            cnt_r   <= CNT_ZERO;
            idx_r   <= 3'd0;
            line_r  <= shift_r[0];
            state_r <= DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (bit_done_s) begin
            cnt_r <= CNT_ZERO;
            if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              line_r  <= even_parity(shift_r);
              state_r <= PARITY;
`else
              line_r  <= 1'b1;
              state_r <= STOP;
`endif
            end else begin
              idx_r  <= idx_r + 3'd1;
              line_r <= shift_r[idx_r + 3'd1];
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done_s) begin
            cnt_r   <= CNT_ZERO;
            line_r  <= 1'b1;
            state_r <= STOP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (bit_done_s) begin
            cnt_r   <= CNT_ZERO;
            line_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          cnt_r   <= CNT_ZERO;
          line_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboarded bench for uart_transmitter: accepted sends queue an expected
// frame; a line monitor checks every cycle of each frame it sees.
module tb_uart_transmitter;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * C;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic clk;
  logic btn0;
  int   cyc;
  int   checks;
  int   failures;
  bit   mon_en;
  exp_t sb_q[$];

  uart_transmitter_if dut_if ();

  uart_transmitter #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .btn0  (btn0),
    .tx_if (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level for frame bit b: start, data LSB first, [parity], stop.
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    logic [7:0] v;
    v = d;
    if (b == 0) return 1'b0;
    if (b <= 8) return v[b-1];
    if (NBITS == 11 && b == 9) return ^v;
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: any falling line edge while enabled is a frame to be checked.
  always begin : monitor
    exp_t e;
    bit   have;
    int   line_errs;
    int   busy_errs;
    int   st;
    @(negedge clk);
    if (mon_en && dut_if.onebit_data === 1'b0) begin
      st = cyc;
      have = 1'b0;
      line_errs = 0;
      busy_errs = 0;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: actual=frame at cycle %0d required=no frame", st);
      end else begin
        e = sb_q.pop_front();
        have = 1'b1;
      end
      for (int t = 0; t < FRAME; t++) begin
        if (t > 0) @(negedge clk);
        if (have && dut_if.onebit_data !== frame_bit(e.data, t / C)) line_errs++;
        if (dut_if.busy !== 1'b1) busy_errs++;
      end
      @(negedge clk);
      if (have) begin
        check("start_time", st, e.start);
        check("frame_line_errs", line_errs, 0);
        check("frame_busy_errs", busy_errs, 0);
        check("led_after_frame", int'(dut_if.led), int'(e.data));
        check("idle_after_frame", int'({dut_if.onebit_data, dut_if.busy}), 2);
      end
    end
  end

  task automatic send(input logic [7:0] b, input int hold, input bit rep);
    int st;
    exp_t e;
    @(negedge clk);
    dut_if.sw   = b;
    dut_if.btn1 = 1'b1;
    st = cyc + 3;
    e.data  = b;
    e.start = st;
    sb_q.push_back(e);
    repeat (hold) @(negedge clk);
    dut_if.btn1 = 1'b0;
    wait_until(st + 1);
    dut_if.sw = ~b;
    if (rep) begin
      wait_until(st + 5 * C);
      dut_if.sw   = 8'hFF;
      dut_if.btn1 = 1'b1;
      repeat (3) @(negedge clk);
      dut_if.btn1 = 1'b0;
    end
    wait_until(st + FRAME + 4);
    dut_if.btn1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int st;
    cyc = 0;
    checks = 0;
    failures = 0;
    mon_en = 1'b0;
    btn0 = 1'b1;
    dut_if.btn1 = 1'b0;
    dut_if.sw = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_line", int'(dut_if.onebit_data), 1);
    check("reset_busy", int'(dut_if.busy), 0);
    check("reset_led", int'(dut_if.led), 0);
    btn0 = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;

    send(8'hA5, 1, 1'b0);
    send(8'h3C, 200, 1'b0);
    check("held_btn_line", int'(dut_if.onebit_data), 1);
    check("held_btn_busy", int'(dut_if.busy), 0);
    send(8'h3C, 2, 1'b1);
    check("repress_led", int'(dut_if.led), 8'h3C);
    send(8'h01, 2, 1'b0);

    // Abort a frame with reset during data bit 3.
    mon_en = 1'b0;
    @(negedge clk);
    dut_if.sw   = 8'h00;
    dut_if.btn1 = 1'b1;
    st = cyc + 3;
    repeat (2) @(negedge clk);
    dut_if.btn1 = 1'b0;
    wait_until(st + 4 * C + 1);
    btn0 = 1'b1;
    @(negedge clk);
    check("midreset_line", int'(dut_if.onebit_data), 1);
    check("midreset_busy", int'(dut_if.busy), 0);
    check("midreset_led", int'(dut_if.led), 0);
    btn0 = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    check("abandoned_line", int'(dut_if.onebit_data), 1);
    check("abandoned_busy", int'(dut_if.busy), 0);
    mon_en = 1'b1;
    send(8'h5A, 3, 1'b0);

    for (int i = 0; i < 10; i++) begin
      send(8'($urandom_range(0, 255)), int'($urandom_range(1, 8)),
           1'($urandom_range(0, 1)));
    end

    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
